// File: rtl/rom_bus_pkg.sv
// Shared definitions for the 4-bit bus ROM bridge: widths, nibble slots and
// the instruction-cycle phase encoding.
package rom_bus_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int NIBBLE_W = 4;

    localparam int NIB_A1 = 0;
    localparam int NIB_A2 = 1;
    localparam int NIB_A3 = 2;

    typedef enum logic [3:0] {
        PH_UNSYNC = 4'd0,
        PH_A1     = 4'd1,
        PH_A2     = 4'd2,
        PH_A3     = 4'd3,
        PH_M1     = 4'd4,
        PH_M2     = 4'd5,
        PH_X1     = 4'd6,
        PH_X2     = 4'd7,
        PH_X3     = 4'd8
    } phase_e;

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_UNSYNC: next_phase = PH_UNSYNC;
            PH_X3:     next_phase = PH_A1;
            default:   next_phase = phase_e'(ph + 4'd1);
        endcase
    endfunction

endpackage

// File: rtl/rom_bus_phase_tracker.sv
// Follows the CPU's 8-phase instruction cycle from sync, freezing while halted.
// resync_err pulses for one cycle when sync arrives anywhere but X3/UNSYNC.
module rom_bus_phase_tracker
    import rom_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sync,
    input  logic       halt,
    output logic [3:0] phase,
    output logic       resync_err
);

    phase_e state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PH_UNSYNC;
            resync_err <= 1'b0;
        end else begin
            resync_err <= sync && (state != PH_X3) && (state != PH_UNSYNC);
            if (sync) begin
                state <= PH_A1;
            end else if (!halt) begin
                state <= next_phase(state);
            end
        end
    end

    assign phase = state;

endmodule

// File: rtl/rom_bus_bridge.sv
// ROM interface on the CPU's multiplexed 4-bit bus: captures A1..A3, fetches a
// byte over req/ack and returns it in M1/M2. Optional single-entry cache: ROM_BRIDGE_CACHE_EN.
module rom_bus_bridge
    import rom_bus_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        cpu_data_i,
    input  logic              cpu_data_en_i,
    input  logic              sync_i,
    input  logic              rom_cmd_i,
    output logic [3:0]        data_o,
    output logic              data_en_o,
    output logic              halt_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [3:0]        phase_o
);

    logic [3:0]        phase_raw;
    phase_e            phase;
    logic              resync_err;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] fetched_byte;
    logic              byte_valid;
    logic              selected;
    logic              mem_req;
    logic              cache_hit;

    rom_bus_phase_tracker u_phase (
        .clock      (clock),
        .reset_n    (reset_n),
        .sync       (sync_i),
        .halt       (halt_o),
        .phase      (phase_raw),
        .resync_err (resync_err)
    );

    assign phase = phase_e'(phase_raw);

    // resync_err only ever coincides with A1, so folding it into the MSB yields
    // a distinct code (9) rather than aliasing another phase.
    assign phase_o = {phase_raw[3] | resync_err, phase_raw[2:0]};

    // Address nibbles are ignored while a request is in flight so the memory
    // sees a stable address for the whole handshake.
    always_comb begin
        addr_next = addr;
        if (cpu_data_en_i && !mem_req) begin
            case (phase)
                PH_A1:   addr_next[NIB_A1*NIBBLE_W +: NIBBLE_W] = cpu_data_i;
                PH_A2:   addr_next[NIB_A2*NIBBLE_W +: NIBBLE_W] = cpu_data_i;
                PH_A3:   addr_next[NIB_A3*NIBBLE_W +: NIBBLE_W] = cpu_data_i;
                default: ;
            endcase
        end
    end

`ifdef ROM_BRIDGE_CACHE_EN
    logic [ADDR_W-1:0] tag_addr;
    logic              tag_valid;

    // fetched_byte is only written on ack, so it always holds the tagged byte.
    assign cache_hit = tag_valid && (tag_addr == addr_next) && !mem_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_addr  <= '0;
            tag_valid <= 1'b0;
        end else if (mem_req && mem_ack_i) begin
            tag_addr  <= addr;
            tag_valid <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // The A3 decision is evaluated after the ack so a new fetch issued on the
    // same edge as a late ack still wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= '0;
            fetched_byte <= '0;
            byte_valid   <= 1'b0;
            selected     <= 1'b0;
            mem_req      <= 1'b0;
        end else begin
            addr <= addr_next;
            if (mem_req && mem_ack_i) begin
                fetched_byte <= mem_rdata_i;
                byte_valid   <= 1'b1;
                mem_req      <= 1'b0;
            end
            if (phase == PH_A3) begin
                selected <= rom_cmd_i;
                if (rom_cmd_i) begin
                    if (cache_hit) begin
                        byte_valid <= 1'b1;
                    end else begin
                        mem_req    <= 1'b1;
                        byte_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign mem_req_o  = mem_req;
    assign mem_addr_o = addr;
    assign halt_o     = (phase == PH_M1) && selected && !byte_valid;

    always_comb begin
        data_o    = '0;
        data_en_o = 1'b0;
        if (selected) begin
            if ((phase == PH_M1) && byte_valid) begin
                data_o    = fetched_byte[DATA_W-1 -: NIBBLE_W];
                data_en_o = 1'b1;
            end else if (phase == PH_M2) begin
                data_o    = fetched_byte[NIBBLE_W-1:0];
                data_en_o = 1'b1;
            end
        end
    end

endmodule
